// File: rtl/ave8_pkg.sv
// rtl/ave8_pkg.sv - shared types and helpers for the ave8 threshold monitor
//
// Contents:
//   AVE8_W      sample width of the moving-average stream
//   REC_CNT_W   width of the count field carried in a window record
//   mon_state_e hysteresis detector state
//   win_rec_t   window statistics record {min, max, cnt}
//   lo_thr()    re-arm threshold, thr - hyst saturated at 0, 9-bit result
package ave8_pkg;

  localparam int AVE8_W    = 8;
  // Fixed record field width; CNT_W of the monitor must not exceed this.
  localparam int REC_CNT_W = 16;

  typedef enum logic {
    BELOW = 1'b0,
    ABOVE = 1'b1
  } mon_state_e;

  typedef struct packed {
    logic [AVE8_W-1:0]    min;
    logic [AVE8_W-1:0]    max;
    logic [REC_CNT_W-1:0] cnt;
  } win_rec_t;

  // Computed one bit wider than a sample so the subtraction can never wrap.
  function automatic logic [AVE8_W:0] lo_thr(input logic [AVE8_W-1:0] thr,
                                              input int unsigned      hyst);
    logic [AVE8_W:0] thr_w;
    logic [AVE8_W:0] hyst_w;
    thr_w  = {1'b0, thr};
    hyst_w = (hyst > (2 ** (AVE8_W + 1)) - 1) ? '1 : (AVE8_W + 1)'(hyst);
    if (thr_w >= hyst_w) begin
      return thr_w - hyst_w;
    end
    return '0;
  endfunction

endpackage

// File: rtl/ave8_thresh_mon_if.sv
// rtl/ave8_thresh_mon_if.sv - window record valid/ready readout interface
//
// Signals:
//   stat_valid  record available (producer)
//   stat_ready  consumer accepts record (consumer)
//   stat_min    minimum sample in the window
//   stat_max    maximum sample in the window
//   stat_cnt    armed upward crossings in the window
//   stat_ovf    sticky: a completed window was dropped
// Modports: master = record producer, slave = register/readout logic.
interface ave8_thresh_mon_if #(
  parameter int CNT_W = 8
);

  logic             stat_valid;
  logic             stat_ready;
  logic [7:0]       stat_min;
  logic [7:0]       stat_max;
  logic [CNT_W-1:0] stat_cnt;
  logic             stat_ovf;

  modport master (
    output stat_valid, stat_min, stat_max, stat_cnt, stat_ovf,
    input  stat_ready
  );

  modport slave (
    input  stat_valid, stat_min, stat_max, stat_cnt, stat_ovf,
    output stat_ready
  );

endinterface

// File: rtl/ave8_win_stats.sv
// rtl/ave8_win_stats.sv - per-window running min/max/crossing accumulator
//
// Ports:
//   CLOCK        rising-edge clock
//   RESET        synchronous active-high reset
//   clr_i        synchronous soft clear, same effect as RESET
//   smp_valid_i  sample strobe (already masked by clr in the caller)
//   smp_i        sample value
//   smp_cross_i  this sample produced an armed upward crossing
//   done_o       combinational: this sample completes the window
//   rec_o        combinational: record including this sample, valid with done_o
module ave8_win_stats
  import ave8_pkg::*;
#(
  parameter int WIN_LEN = 64,
  parameter int CNT_W   = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              clr_i,
  input  logic              smp_valid_i,
  input  logic [AVE8_W-1:0] smp_i,
  input  logic              smp_cross_i,
  output logic              done_o,
  output win_rec_t          rec_o
);

  localparam int IDX_W = $clog2(WIN_LEN);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [AVE8_W-1:0] min_q, min_d;
  logic [AVE8_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Running values with the current sample folded in.
  logic [AVE8_W-1:0] min_n;
  logic [AVE8_W-1:0] max_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              last_smp;

  always_comb begin
    min_n    = (smp_i < min_q) ? smp_i : min_q;
    max_n    = (smp_i > max_q) ? smp_i : max_q;
    cnt_n    = (smp_cross_i && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    last_smp = (idx_q == IDX_W'(WIN_LEN - 1));

    done_o    = smp_valid_i && last_smp;
    rec_o.min = min_n;
    rec_o.max = max_n;
    rec_o.cnt = REC_CNT_W'(cnt_n);

    idx_d = idx_q;
    min_d = min_q;
    max_d = max_q;
    cnt_d = cnt_q;
    if (smp_valid_i) begin
      // Power-of-two window: the index wraps to 0 on the last sample.
      idx_d = idx_q + IDX_W'(1);
      if (last_smp) begin
        min_d = '1;
        max_d = '0;
        cnt_d = '0;
      end else begin
        min_d = min_n;
        max_d = max_n;
        cnt_d = cnt_n;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || clr_i) begin
      idx_q <= '0;
      min_q <= '1;
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      min_q <= min_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ave8_thresh_mon.sv
// rtl/ave8_thresh_mon.sv - hysteresis threshold monitor with windowed statistics
//
// Ports:
//   CLOCK      rising-edge clock
//   RESET      synchronous active-high reset
//   avg_in     registered 8-tap moving average sample
//   avg_valid  avg_in is a new sample this cycle
//   thr_hi     upper threshold, used only on avg_valid cycles
//   clr        soft clear of window, detector and overflow flag
//   cross_o    one-cycle pulse per armed upward crossing
//   above_o    detector state, 1 = ABOVE
//   stat       window record readout (master side)
module ave8_thresh_mon
  import ave8_pkg::*;
#(
  parameter int WIN_LEN = 64,
  parameter int HYST    = 4,
  parameter int CNT_W   = 8
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [AVE8_W-1:0]         avg_in,
  input  logic                      avg_valid,
  input  logic [AVE8_W-1:0]         thr_hi,
  input  logic                      clr,
  output logic                      cross_o,
  output logic                      above_o,
  ave8_thresh_mon_if.master         stat
);

  mon_state_e      state_q, state_d;
  logic            cross_q, cross_d;
  logic [AVE8_W:0] lo_w;
  logic            smp_valid;

  // clr wins over a coincident sample; that sample is simply lost.
  assign smp_valid = avg_valid && !clr;
  assign lo_w      = lo_thr(thr_hi, HYST);

  always_comb begin
    state_d = state_q;
    cross_d = 1'b0;
    if (smp_valid) begin
      case (state_q)
        BELOW: begin
          if ({1'b0, avg_in} >= {1'b0, thr_hi}) begin
            state_d = ABOVE;
            cross_d = 1'b1;
          end
        end
        ABOVE: begin
          // With thr_hi < HYST the re-arm level is 0 and this never fires.
          if ({1'b0, avg_in} < lo_w) begin
            state_d = BELOW;
          end
        end
        default: state_d = BELOW;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || clr) begin
      state_q <= BELOW;
      cross_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cross_q <= cross_d;
    end
  end

  assign cross_o = cross_q;
  assign above_o = (state_q == ABOVE);

  logic     done;
  win_rec_t done_rec;

  ave8_win_stats #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) u_win_stats (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .clr_i       (clr),
    .smp_valid_i (smp_valid),
    .smp_i       (avg_in),
    .smp_cross_i (cross_d),
    .done_o      (done),
    .rec_o       (done_rec)
  );

  // Output slot: one held record plus the sticky drop flag.
  logic              slot_valid_q, slot_valid_d;
  logic [AVE8_W-1:0] slot_min_q, slot_min_d;
  logic [AVE8_W-1:0] slot_max_q, slot_max_d;
  logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic              ovf_q, ovf_d;
  logic              unused_rec_cnt;

  assign unused_rec_cnt = ^done_rec.cnt;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_min_d   = slot_min_q;
    slot_max_d   = slot_max_q;
    slot_cnt_d   = slot_cnt_q;
    ovf_d        = ovf_q;
    if (slot_valid_q && stat.stat_ready) begin
      slot_valid_d = 1'b0;
    end
    if (done) begin
      // A record being accepted this cycle frees the slot for the new one.
      if (!slot_valid_q || stat.stat_ready) begin
        slot_valid_d = 1'b1;
        slot_min_d   = done_rec.min;
        slot_max_d   = done_rec.max;
        slot_cnt_d   = done_rec.cnt[CNT_W-1:0];
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || clr) begin
      slot_valid_q <= 1'b0;
      slot_min_q   <= '0;
      slot_max_q   <= '0;
      slot_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_min_q   <= slot_min_d;
      slot_max_q   <= slot_max_d;
      slot_cnt_q   <= slot_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign stat.stat_valid = slot_valid_q;
  assign stat.stat_min   = slot_min_q;
  assign stat.stat_max   = slot_max_q;
  assign stat.stat_cnt   = slot_cnt_q;
  assign stat.stat_ovf   = ovf_q;

endmodule

// File: tb/tb_ave8_thresh_mon.sv
// tb/tb_ave8_thresh_mon.sv - self-checking bench for ave8_thresh_mon
module tb_ave8_thresh_mon;

  localparam int WIN = 4;
  localparam int HY  = 4;
  localparam int CW  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_s;
  logic       v;
  logic [7:0] x;
  logic [7:0] thr;
  logic       cross_w;
  logic       above_w;

  always #5 clk = ~clk;

  ave8_thresh_mon_if #(.CNT_W(CW)) sif ();

  ave8_thresh_mon #(
    .WIN_LEN (WIN),
    .HYST    (HY),
    .CNT_W   (CW)
  ) dut (
    .CLOCK     (clk),
    .RESET     (rst),
    .avg_in    (x),
    .avg_valid (v),
    .thr_hi    (thr),
    .clr       (clr_s),
    .cross_o   (cross_w),
    .above_o   (above_w),
    .stat      (sif)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: detector flag, open window as a list, held record.
  bit m_above, m_cross, m_valid, m_ovf;
  int m_min, m_max, m_cnt;
  int win_q[$];
  int xq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit c, input bit vv,
                              input int xx, input bit rdy, input int t);
    int lo, mn, mx, nc;
    bit loaded;
    loaded = 1'b0;
    if (r || c) begin
      m_above = 0; m_cross = 0; m_valid = 0; m_ovf = 0;
      m_min = 0; m_max = 0; m_cnt = 0;
      win_q.delete(); xq.delete();
      return;
    end
    m_cross = 0;
    if (vv) begin
      lo = (t >= HY) ? t - HY : 0;
      if (!m_above && xx >= t) begin
        m_above = 1; m_cross = 1;
      end else if (m_above && xx < lo) begin
        m_above = 0;
      end
      win_q.push_back(xx);
      xq.push_back(int'(m_cross));
      if (win_q.size() == WIN) begin
        mn = 255; mx = 0; nc = 0;
        foreach (win_q[i]) begin
          if (win_q[i] < mn) mn = win_q[i];
          if (win_q[i] > mx) mx = win_q[i];
          nc += xq[i];
        end
        if (nc > (1 << CW) - 1) nc = (1 << CW) - 1;
        if (!m_valid || rdy) begin
          m_min = mn; m_max = mx; m_cnt = nc; loaded = 1'b1;
        end else begin
          m_ovf = 1;
        end
        win_q.delete(); xq.delete();
      end
    end
    if (loaded) m_valid = 1;
    else if (m_valid && rdy) m_valid = 0;
  endtask

  task automatic step(input bit r, input bit c, input bit vv, input int xx, input bit rdy);
    rst = r; clr_s = c; v = vv; x = xx[7:0]; sif.stat_ready = rdy;
    @(posedge clk);
    model_update(r, c, vv, xx, rdy, int'(thr));
    #1;
  endtask

  task automatic feed(input int xx, input bit rdy);
    step(1'b0, 1'b0, 1'b1, xx, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 0, rdy);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cross_o", int'(cross_w), int'(m_cross));
      chk("above_o", int'(above_w), int'(m_above));
      chk("stat_valid", int'(sif.stat_valid), int'(m_valid));
      chk("stat_ovf", int'(sif.stat_ovf), int'(m_ovf));
      if (m_valid) begin
        chk("stat_min", int'(sif.stat_min), m_min);
        chk("stat_max", int'(sif.stat_max), m_max);
        chk("stat_cnt", int'(sif.stat_cnt), m_cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; clr_s = 1'b0; v = 1'b0; x = 8'd0; thr = 8'd100;
    sif.stat_ready = 1'b0;

    // Reset for two cycles with avg_valid toggling.
    step(1'b1, 1'b0, 1'b1, 150, 1'b0);
    cmp_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 150, 1'b0);
    chk("rst_valid", int'(sif.stat_valid), 0);
    chk("rst_cross", int'(cross_w), 0);
    chk("rst_above", int'(above_w), 0);
    chk("rst_ovf", int'(sif.stat_ovf), 0);

    // Hysteresis sequence, thr_hi=100, lo=96.
    feed(90, 1);  chk("h90_cross", int'(cross_w), 0);
    feed(100, 1); chk("h100_cross", int'(cross_w), 1); chk("h100_above", int'(above_w), 1);
    feed(99, 1);  chk("h99_cross", int'(cross_w), 0); chk("win_not_early", int'(sif.stat_valid), 0);
    feed(97, 1);  chk("w1_valid", int'(sif.stat_valid), 1);
    chk("w1_min", int'(sif.stat_min), 90); chk("w1_max", int'(sif.stat_max), 100);
    chk("w1_cnt", int'(sif.stat_cnt), 1);
    feed(96, 1);  chk("h96_above", int'(above_w), 1); chk("w1_drained", int'(sif.stat_valid), 0);
    feed(95, 1);  chk("h95_above", int'(above_w), 0); chk("h95_cross", int'(cross_w), 0);
    feed(101, 1); chk("h101_cross", int'(cross_w), 1);
    feed(50, 1);  chk("w2_min", int'(sif.stat_min), 50); chk("w2_max", int'(sif.stat_max), 101);

    // Gapped input, thr_hi=150.
    thr = 8'd150;
    feed(10, 1);  idle(1);
    feed(200, 1); chk("g200_cross", int'(cross_w), 1);
    idle(1); idle(1);
    feed(3, 1);   idle(1);
    feed(50, 1);
    chk("g_valid", int'(sif.stat_valid), 1);
    chk("g_min", int'(sif.stat_min), 3); chk("g_max", int'(sif.stat_max), 200);
    chk("g_cnt", int'(sif.stat_cnt), 1);
    chk("model_g_min", m_min, 3); chk("model_g_cnt", m_cnt, 1);

    // Backpressure and overflow.
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("clr_valid", int'(sif.stat_valid), 0);
    feed(5, 0); feed(6, 0); feed(7, 0); feed(8, 0);
    chk("bp1_valid", int'(sif.stat_valid), 1); chk("bp1_ovf", int'(sif.stat_ovf), 0);
    feed(20, 0); feed(30, 0); feed(40, 0); feed(50, 0);
    chk("bp2_ovf", int'(sif.stat_ovf), 1);
    chk("bp2_held_min", int'(sif.stat_min), 5); chk("bp2_held_max", int'(sif.stat_max), 8);
    idle(1);
    chk("bp_accept", int'(sif.stat_valid), 0); chk("bp_ovf_sticky", int'(sif.stat_ovf), 1);
    idle(0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("ovf_cleared", int'(sif.stat_ovf), 0);

    // Accept and load in the same cycle.
    feed(1, 0); feed(2, 0); feed(3, 0); feed(4, 0);
    chk("sa1_max", int'(sif.stat_max), 4);
    feed(9, 0); feed(8, 0); feed(7, 0); feed(6, 1);
    chk("sa_valid", int'(sif.stat_valid), 1);
    chk("sa_min", int'(sif.stat_min), 6); chk("sa_max", int'(sif.stat_max), 9);
    chk("sa_ovf", int'(sif.stat_ovf), 0);
    idle(1);
    chk("sa_drain", int'(sif.stat_valid), 0);

    // Mid-window clr with a coincident sample.
    feed(11, 1); feed(12, 1);
    step(1'b0, 1'b1, 1'b1, 250, 1'b1);
    chk("mclr_cross", int'(cross_w), 0); chk("mclr_above", int'(above_w), 0);
    feed(40, 1); feed(41, 1); feed(42, 1);
    chk("mclr_no_rec", int'(sif.stat_valid), 0);
    feed(43, 1);
    chk("mclr_min", int'(sif.stat_min), 40); chk("mclr_max", int'(sif.stat_max), 43);
    chk("mclr_ovf", int'(sif.stat_ovf), 0);

    // Mid-window reset.
    feed(60, 1); feed(61, 1);
    step(1'b1, 1'b0, 1'b1, 250, 1'b1);
    feed(70, 1); feed(71, 1); feed(72, 1);
    chk("mrst_no_rec", int'(sif.stat_valid), 0);
    feed(73, 1);
    chk("mrst_min", int'(sif.stat_min), 70); chk("mrst_max", int'(sif.stat_max), 73);

    // Edge threshold: thr_hi=2 < HYST, re-arm level saturates at 0.
    thr = 8'd2;
    step(1'b0, 1'b1, 1'b0, 0, 1'b1);
    feed(2, 1); chk("e2_cross", int'(cross_w), 1); chk("e2_above", int'(above_w), 1);
    feed(0, 1); chk("e0_cross", int'(cross_w), 0); chk("e0_above", int'(above_w), 1);
    feed(0, 1); chk("e0b_above", int'(above_w), 1);
    feed(0, 1);
    chk("e_min", int'(sif.stat_min), 0); chk("e_max", int'(sif.stat_max), 2);
    chk("e_cnt", int'(sif.stat_cnt), 1); chk("e_above_end", int'(above_w), 1);

    idle(1);
    @(posedge clk);
    cmp_en = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
